// File: rtl/seq_detector_param.sv
// Serial pattern detector: debounced key strobes one switch bit per press into a
// shift history; matches raise a pulse, a saturating count and a stretched success flag.
//   state | meaning
//   IDLE  | no recent match, success_output low
//   HOLD  | success_output high, hold_cnt counting down to 0
//   FLUSH | one-clock gap after a hold ends before returning to IDLE
`timescale 1ns/100ps
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter int                     HOLD_CYCLES = 8,
  parameter int                     COUNT_W     = 6,
  localparam int                    BW          = $clog2(PATTERN_LEN + 1),
  localparam int                    HW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key1,
  input  logic                   switch0,
  input  logic                   enable,
  input  logic                   count_clr,
  output logic [BW-1:0]          bits_seen,
  output logic [PATTERN_LEN-1:0] history,
  output logic                   match_pulse,
  output logic                   success_output,
  output logic [COUNT_W-1:0]     count_z,
  output logic [1:0]             current_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BITS_MAX  = BW'(PATTERN_LEN);

  state_t                   state;
  logic [HW-1:0]            hold_cnt;
  logic                     k1, k2, k3, s1, s2;
  logic                     strobe;
  logic                     hit;
  logic [PATTERN_LEN-1:0]   next_hist;

  assign strobe        = k2 & ~k3 & enable;
  assign next_hist     = {history[PATTERN_LEN-2:0], s2};
  // a match only counts once enough real bits have been shifted in
  assign hit           = strobe && (next_hist == PATTERN) &&
                         ((int'(bits_seen) + 1) >= PATTERN_LEN);
  assign current_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      k1 <= 1'b0;
      k2 <= 1'b0;
      k3 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      k1 <= key1;
      k2 <= k1;
      k3 <= k2;
      s1 <= switch0;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history     <= '0;
      bits_seen   <= '0;
      match_pulse <= 1'b0;
    end else begin
      match_pulse <= hit;
      if (hit && !OVERLAP) begin
        history   <= '0;
        bits_seen <= '0;
      end else if (strobe) begin
        history <= next_hist;
        if (bits_seen != BITS_MAX) bits_seen <= bits_seen + 1'b1;
      end
    end
  end

  // clear has priority over a coincident match
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_z <= '0;
    end else if (count_clr) begin
      count_z <= '0;
    end else if (hit && (count_z != '1)) begin
      count_z <= count_z + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      success_output <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state          <= HOLD;
            hold_cnt       <= HOLD_LOAD;
            success_output <= 1'b1;
          end
        end
        HOLD: begin
          if (hit) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == '0) begin
            state          <= FLUSH;
            success_output <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        FLUSH: begin
          if (hit) begin
            state          <= HOLD;
            hold_cnt       <= HOLD_LOAD;
            success_output <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          success_output <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default instance plus OVERLAP=0 and
// COUNT_W=2 variants sharing one stimulus stream.
`timescale 1ns/100ps
module tb_seq_detector_param;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic key1 = 1'b0, switch0 = 1'b0, enable = 1'b0, count_clr = 1'b0;

  logic [2:0] bs_a, bs_b, bs_c;
  logic [3:0] h_a, h_b, h_c;
  logic       mp_a, mp_b, mp_c, so_a, so_b, so_c;
  logic [5:0] cz_a, cz_b;
  logic [1:0] cz_c;
  logic [1:0] st_a, st_b, st_c;

  int checks = 0;
  int errors = 0;
  int np_a = 0, ns_a = 0;
  int na0, ns0;
  logic [31:0] pmask;

  always #1 clock = ~clock;

  always @(negedge clock) begin
    if (mp_a) np_a <= np_a + 1;
    if (so_a) ns_a <= ns_a + 1;
  end

  seq_detector_param dut_a (
    .clock(clock), .reset(reset), .key1(key1), .switch0(switch0), .enable(enable),
    .count_clr(count_clr), .bits_seen(bs_a), .history(h_a), .match_pulse(mp_a),
    .success_output(so_a), .count_z(cz_a), .current_state(st_a));

  seq_detector_param #(.OVERLAP(1'b0)) dut_b (
    .clock(clock), .reset(reset), .key1(key1), .switch0(switch0), .enable(enable),
    .count_clr(count_clr), .bits_seen(bs_b), .history(h_b), .match_pulse(mp_b),
    .success_output(so_b), .count_z(cz_b), .current_state(st_b));

  seq_detector_param #(.COUNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .key1(key1), .switch0(switch0), .enable(enable),
    .count_clr(count_clr), .bits_seen(bs_c), .history(h_c), .match_pulse(mp_c),
    .success_output(so_c), .count_z(cz_c), .current_state(st_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pmask bit i = match_pulse seen i negedges after the key1 rise
  task automatic press(input logic b, input int hi_cyc, input logic en, input logic clr);
    switch0 = b;
    enable  = en;
    repeat (4) @(negedge clock);
    key1  = 1'b1;
    pmask = '0;
    for (int i = 0; i < hi_cyc; i++) begin
      @(negedge clock);
      if (mp_a && i < 32) pmask[i] = 1'b1;
      if (clr) count_clr = (i == 1);
    end
    key1   = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic fast_bits(input logic [6:0] v);
    for (int i = 6; i >= 0; i--) begin
      switch0 = v[i];
      key1    = 1'b1;
      @(negedge clock);
      key1    = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bits"}, 32'(bs_a), 32'd0);
    check({tag, "_hist"}, 32'(h_a), 32'd0);
    check({tag, "_pulse"}, 32'(mp_a), 32'd0);
    check({tag, "_succ"}, 32'(so_a), 32'd0);
    check({tag, "_count"}, 32'(cz_a), 32'd0);
    check({tag, "_state"}, 32'(st_a), 32'd0);
  endtask

  initial begin
    key1 = 1'b1; switch0 = 1'b1; enable = 1'b1; count_clr = 1'b1;
    repeat (3) @(negedge clock);
    check_zero("rst0");
    key1 = 1'b0; switch0 = 1'b0; count_clr = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // basic 1011
    press(1'b1, 4, 1'b1, 1'b0);
    press(1'b0, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    na0 = np_a; ns0 = ns_a;
    press(1'b1, 4, 1'b1, 1'b0);
    check("t2_pulse_pos", pmask, 32'h4);
    check("t2_pulses", 32'(np_a - na0), 32'd1);
    check("t2_count", 32'(cz_a), 32'd1);
    check("t2_bits", 32'(bs_a), 32'd4);
    check("t2_hist", 32'(h_a), 32'hB);
    check("t2_state_hold", 32'(st_a), 32'd1);
    repeat (8) @(negedge clock);
    check("t2_succ_len", 32'(ns_a - ns0), 32'd8);
    check("t2_state_idle", 32'(st_a), 32'd0);

    // overlap continuation 0,1,1
    press(1'b0, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    check("t3_count_ovl", 32'(cz_a), 32'd2);
    check("t3_pulses", 32'(np_a - na0), 32'd2);
    check("t3_count_novl", 32'(cz_b), 32'd1);
    check("t3_bits_novl", 32'(bs_b), 32'd3);
    check("t3_hist_novl", 32'(h_b), 32'h3);

    // reset in the middle of a hold
    check("t1_pre_state", 32'(st_a), 32'd1);
    check("t1_pre_succ", 32'(so_a), 32'd1);
    reset = 1'b0;
    #0.3;
    check_zero("t1");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // short history then a full pattern
    na0 = np_a;
    press(1'b0, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    check("t4_bits", 32'(bs_a), 32'd3);
    check("t4_no_match", 32'(np_a - na0), 32'd0);
    press(1'b1, 4, 1'b1, 1'b0);
    press(1'b0, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    check("t4_one_match", 32'(np_a - na0), 32'd1);
    check("t4_count", 32'(cz_a), 32'd1);
    check("t4_count_novl", 32'(cz_b), 32'd1);

    // saturation of the 2-bit counter
    for (int m = 0; m < 4; m++) begin
      press(1'b0, 4, 1'b1, 1'b0);
      press(1'b1, 4, 1'b1, 1'b0);
      press(1'b1, 4, 1'b1, 1'b0);
    end
    check("t5_count_sat", 32'(cz_c), 32'd3);
    check("t5_count_a", 32'(cz_a), 32'd5);
    check("t5_count_novl", 32'(cz_b), 32'd3);

    // clear on the same edge as a hit
    press(1'b0, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b0);
    press(1'b1, 4, 1'b1, 1'b1);
    check("t5_clr_hit_pulse", pmask, 32'h4);
    check("t5_clr_wins_a", 32'(cz_a), 32'd0);
    check("t5_clr_wins_c", 32'(cz_c), 32'd0);

    // held key and disabled press
    press(1'b0, 20, 1'b1, 1'b0);
    check("t6_held_hist", 32'(h_a), 32'h6);
    check("t6_held_bits_novl", 32'(bs_b), 32'd4);
    press(1'b1, 4, 1'b0, 1'b0);
    check("t6_disabled_hist", 32'(h_a), 32'h6);
    check("t6_disabled_bits_novl", 32'(bs_b), 32'd4);

    // retrigger inside a hold
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    na0 = np_a; ns0 = ns_a;
    fast_bits(7'b1011011);
    repeat (20) @(negedge clock);
    check("t6_retrig_pulses", 32'(np_a - na0), 32'd2);
    check("t6_retrig_succ_len", 32'(ns_a - ns0), 32'd14);
    check("t6_retrig_count", 32'(cz_a), 32'd2);
    check("t6_retrig_idle", 32'(st_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
